multi_alarm_timekeeper: RTL and testbench

MULTI_ALARM_TIMEKEEPER -- requirements
Module: multi_alarm_timekeeper

---
 rtl/clock_pkg.sv | 86 ++++++++
 rtl/alarm_channel.sv | 124 ++++++++++++
 rtl/multi_alarm_timekeeper.sv | 139 +++++++++++++
 tb/tb_multi_alarm_timekeeper.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD time types, ring-state encoding and time-arithmetic helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Build option: MULTI_ALARM_SNOOZE_EN adds the SNOOZE ring state.
package clock_pkg;

    // BCD hh:mm:ss, each field two BCD digits.
    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } hms_t;

    // BCD hh:mm, used for alarm set-points.
    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
    } hm_t;

`ifdef MULTI_ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1
    } ring_state_e;
`endif

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_12 = 8'h12;

    // A BCD byte is acceptable when its low digit is a decimal digit and the
    // whole value does not exceed lim. With a legal low digit, BCD ordering
    // matches plain unsigned ordering, so a high digit above the limit fails
    // the magnitude test.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // One-second advance with ss->mm->hh carries and midnight wrap.
    function automatic hms_t hms_next(input hms_t t);
        hms_t n;
        n = t;
        if (t.ss == BCD_59) begin
            n.ss = 8'h00;
            if (t.mm == BCD_59) begin
                n.mm = 8'h00;
                n.hh = (t.hh == BCD_23) ? 8'h00 : bcd_inc(t.hh);
            end else begin
                n.mm = bcd_inc(t.mm);
            end
        end else begin
            n.ss = bcd_inc(t.ss);
        end
        return n;
    endfunction

    // 24-hour BCD hour to 12-hour BCD hour: 00->12, 13..23->01..11.
    function automatic logic [7:0] hour_to_12(input logic [7:0] hh);
        logic [4:0] b;
        logic [4:0] r;
        b = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
        if (b == 5'd0) begin
            r = 5'd12;
        end else if (b > 5'd12) begin
            r = b - 5'd12;
        end else begin
            r = b;
        end
        return (r >= 5'd10) ? {4'd1, 4'(r - 5'd10)} : {4'd0, r[3:0]};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: set-point register, minute compare, ring/snooze FSM.
// Latency: ringing rises one cycle after min_evt matches; ack/wr clear next cycle.
// Backpressure: none; every input is a single-cycle pulse consumed immediately.
//
// Ports: clk/rst (sync, active-high); tick = one-second strobe; min_evt = the
// running time has just become hh:mm:00 by counting; cur_hm = running hh:mm;
// wr/wr_time/wr_en = validated set-point write; ack = stop; snooze (only with
// MULTI_ALARM_SNOOZE_EN); ringing = state is RING.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int RING_SEC     = 60,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic min_evt,
    input  hm_t  cur_hm,
    input  logic wr,
    input  hm_t  wr_time,
    input  logic wr_en,
    input  logic ack,
`ifdef MULTI_ALARM_SNOOZE_EN
    input  logic snooze,
`endif
    output logic ringing
);

    // One counter serves both the ring and snooze intervals, sized for the longer.
    localparam int CNT_TOP = (RING_SEC > SNOOZE_TICKS) ? RING_SEC : SNOOZE_TICKS;
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP + 1) : 1;
    localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);
`ifdef MULTI_ALARM_SNOOZE_EN
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_TICKS - 1);
`endif

    ring_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    hm_t           atime_q, atime_d;
    logic          aen_q, aen_d;
    logic          match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            atime_q <= '0;
            aen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            atime_q <= atime_d;
            aen_q   <= aen_d;
        end
    end

    assign match = min_evt && aen_q && (cur_hm == atime_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        atime_d = atime_q;
        aen_d   = aen_q;
        if (wr) begin
            // Rewriting a channel always silences it.
            atime_d = wr_time;
            aen_d   = wr_en;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Matches are only honoured from IDLE, so a repeat match
                    // never restarts an active ring interval.
                    if (match) begin
                        state_d = ST_RING;
                        cnt_d   = '0;
                    end
                end
                ST_RING: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
`ifdef MULTI_ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_d = ST_SNOOZE;
                        cnt_d   = '0;
`endif
                    end else if (tick) begin
                        if (cnt_q == RING_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
`ifdef MULTI_ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == SNOOZE_LAST) begin
                            state_d = ST_RING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign ringing = (state_q == ST_RING);

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// BCD time-of-day clock with 12/24-hour display and NUM_ALARMS alarm channels.
// Latency: time/chime/load_err/alarm state update one cycle after the cause.
// Backpressure: none; load, alarm_wr, ack and snooze are accepted every cycle.
//
// Ports: CP clock, _CR sync active-high reset; time_mode selects 12-hour
// display; load/load_time preload hh:mm:ss; alarm_wr/alarm_sel/alarm_time/
// alarm_en program one channel; ack stops all channels; snooze (only with
// MULTI_ALARM_SNOOZE_EN). Outputs: cur_time, disp_time, pm, sec_tick,
// hour_chime, ringing[NUM_ALARMS], load_err.
module multi_alarm_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  CP,
    input  logic                  _CR,
    input  logic                  time_mode,
    input  logic                  load,
    input  logic [23:0]           load_time,
    input  logic                  alarm_wr,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] alarm_sel,
    input  logic [15:0]           alarm_time,
    input  logic                  alarm_en,
    input  logic                  ack,
`ifdef MULTI_ALARM_SNOOZE_EN
    input  logic                  snooze,
`endif
    output logic [23:0]           cur_time,
    output logic [23:0]           disp_time,
    output logic                  pm,
    output logic                  sec_tick,
    output logic                  hour_chime,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  load_err
);

    localparam int SW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    hms_t          cur_time_q, cur_time_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          hour_chime_q, hour_chime_d;
    logic          min_evt_q, min_evt_d;
    logic          load_err_q, load_err_d;

    hms_t          ld;
    hm_t           at;
    hm_t           cur_hm;
    hms_t          disp_s;
    logic          tick;
    logic          load_ok;
    logic          alarm_ok;

    assign ld = hms_t'(load_time);
    assign at = hm_t'(alarm_time);

    assign tick     = (pre_q == PRE_LAST);
    assign load_ok  = bcd_ok(ld.hh, BCD_23) && bcd_ok(ld.mm, BCD_59) && bcd_ok(ld.ss, BCD_59);
    assign alarm_ok = bcd_ok(at.hh, BCD_23) && bcd_ok(at.mm, BCD_59);

    always_ff @(posedge CP) begin
        if (_CR) begin
            cur_time_q   <= '0;
            pre_q        <= '0;
            hour_chime_q <= 1'b0;
            min_evt_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            cur_time_q   <= cur_time_d;
            pre_q        <= pre_d;
            hour_chime_q <= hour_chime_d;
            min_evt_q    <= min_evt_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        cur_time_d   = cur_time_q;
        pre_d        = tick ? '0 : pre_q + PW'(1);
        hour_chime_d = 1'b0;
        min_evt_d    = 1'b0;
        load_err_d   = (load && !load_ok) || (alarm_wr && !alarm_ok);
        if (load && load_ok) begin
            // A valid load wins over a coincident tick and restarts the second,
            // and never raises the chime or minute events.
            cur_time_d = ld;
            pre_d      = '0;
        end else if (tick) begin
            cur_time_d   = hms_next(cur_time_q);
            min_evt_d    = (cur_time_q.ss == BCD_59);
            hour_chime_d = (cur_time_q.ss == BCD_59) && (cur_time_q.mm == BCD_59);
        end
    end

    // 12-hour display only rewrites the hour field.
    always_comb begin
        disp_s = cur_time_q;
        pm     = 1'b0;
        if (time_mode) begin
            disp_s.hh = hour_to_12(cur_time_q.hh);
            pm        = (cur_time_q.hh >= BCD_12);
        end
    end

    assign cur_time   = cur_time_q;
    assign disp_time  = disp_s;
    assign sec_tick   = tick;
    assign hour_chime = hour_chime_q;
    assign load_err   = load_err_q;
    assign cur_hm     = {cur_time_q.hh, cur_time_q.mm};

    // min_evt_q is high in the cycle cur_time first shows hh:mm:00 after a
    // counted second, so channels compare against the settled time.
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .RING_SEC     (RING_SEC),
            .SNOOZE_TICKS (SNOOZE_MIN * 60)
        ) u_ch (
            .clk     (CP),
            .rst     (_CR),
            .tick    (tick),
            .min_evt (min_evt_q),
            .cur_hm  (cur_hm),
            .wr      (alarm_wr && alarm_ok && (alarm_sel == SW'(i))),
            .wr_time (at),
            .wr_en   (alarm_en),
            .ack     (ack),
`ifdef MULTI_ALARM_SNOOZE_EN
            .snooze  (snooze),
`endif
            .ringing (ringing[i])
        );
    end

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
module tb_multi_alarm_timekeeper;

    localparam int CLK_HZ = 10;
    localparam int NA     = 4;

    logic          CP = 1'b0;
    logic          cr = 1'b1;
    logic          time_mode = 1'b0;
    logic          load = 1'b0;
    logic [23:0]   load_time = '0;
    logic          alarm_wr = 1'b0;
    logic [1:0]    alarm_sel = '0;
    logic [15:0]   alarm_time = '0;
    logic          alarm_en = 1'b0;
    logic          ack = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
    logic          snooze = 1'b0;
`endif
    logic [23:0]   cur_time;
    logic [23:0]   disp_time;
    logic          pm;
    logic          sec_tick;
    logic          hour_chime;
    logic [NA-1:0] ringing;
    logic          load_err;

    int n_cmp = 0;
    int n_bad = 0;

    multi_alarm_timekeeper #(
        .CLK_HZ     (CLK_HZ),
        .NUM_ALARMS (NA),
        .RING_SEC   (60),
        .SNOOZE_MIN (5)
    ) dut (
        .CP         (CP),
        ._CR        (cr),
        .time_mode  (time_mode),
        .load       (load),
        .load_time  (load_time),
        .alarm_wr   (alarm_wr),
        .alarm_sel  (alarm_sel),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .ack        (ack),
`ifdef MULTI_ALARM_SNOOZE_EN
        .snooze     (snooze),
`endif
        .cur_time   (cur_time),
        .disp_time  (disp_time),
        .pm         (pm),
        .sec_tick   (sec_tick),
        .hour_chime (hour_chime),
        .ringing    (ringing),
        .load_err   (load_err)
    );

    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse load for one cycle; returns at the negedge after the capturing edge.
    task automatic do_load(input logic mode, input logic [23:0] t);
        @(negedge CP);
        time_mode = mode;
        load_time = t;
        load      = 1'b1;
        @(negedge CP);
        load      = 1'b0;
    endtask

    task automatic wr_alarm(input logic [1:0] sel, input logic [15:0] t, input logic en);
        @(negedge CP);
        alarm_sel  = sel;
        alarm_time = t;
        alarm_en   = en;
        alarm_wr   = 1'b1;
        @(negedge CP);
        alarm_wr   = 1'b0;
    endtask

    // Advance to the next negedge where sec_tick is high; n = negedges taken.
    task automatic wait_tick(output logic ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CP);
            n = i + 1;
            if (sec_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tick_case(input logic [23:0] t, input logic [23:0] e, input logic c);
        logic ok;
        int   n;
        do_load(1'b0, t);
        chk($sformatf("load_no_chime_%h", t), 32'(hour_chime), 32'(0));
        wait_tick(ok, n);
        chk($sformatf("tick_seen_%h", t), 32'(ok), 32'(1));
        chk($sformatf("tick_latency_%h", t), 32'(n), 32'(9));
        @(negedge CP);
        chk($sformatf("tick_time_%h", t), 32'(cur_time), 32'(e));
        chk($sformatf("tick_chime_%h", t), 32'(hour_chime), 32'(c));
        @(negedge CP);
        chk($sformatf("chime_drop_%h", t), 32'(hour_chime), 32'(0));
    endtask

    typedef struct {
        logic        mode;
        logic [23:0] t;
        logic [23:0] e_cur;
        logic [23:0] e_disp;
        logic        e_pm;
        logic        e_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic ok;
        int   n;

        vecs[0]  = '{1'b0, 24'h123456, 24'h123456, 24'h123456, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 24'h250000, 24'h123456, 24'h123456, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 24'h003000, 24'h003000, 24'h123000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 24'h130500, 24'h130500, 24'h010500, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 24'h120000, 24'h120000, 24'h120000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 24'h235959, 24'h235959, 24'h115959, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 24'h115959, 24'h115959, 24'h115959, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 24'h126000, 24'h115959, 24'h115959, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 24'h095A00, 24'h115959, 24'h115959, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 24'h200000, 24'h200000, 24'h200000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 24'h200000, 24'h200000, 24'h080000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 24'h010061, 24'h200000, 24'h080000, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge CP);
        chk("rst_cur_time", 32'(cur_time), 32'(0));
        chk("rst_disp_time", 32'(disp_time), 32'(0));
        chk("rst_pm", 32'(pm), 32'(0));
        chk("rst_sec_tick", 32'(sec_tick), 32'(0));
        chk("rst_hour_chime", 32'(hour_chime), 32'(0));
        chk("rst_ringing", 32'(ringing), 32'(0));
        chk("rst_load_err", 32'(load_err), 32'(0));
        cr = 1'b0;

        // Load / validation / display table
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].mode, vecs[i].t);
            chk($sformatf("vec%0d_cur", i), 32'(cur_time), 32'(vecs[i].e_cur));
            chk($sformatf("vec%0d_disp", i), 32'(disp_time), 32'(vecs[i].e_disp));
            chk($sformatf("vec%0d_pm", i), 32'(pm), 32'(vecs[i].e_pm));
            chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].e_err));
        end
        @(negedge CP);
        chk("load_err_single_pulse", 32'(load_err), 32'(0));

        // Counting, carries and hour chime
        tick_case(24'h235959, 24'h000000, 1'b1);
        tick_case(24'h095959, 24'h100000, 1'b1);
        tick_case(24'h005959, 24'h010000, 1'b1);
        tick_case(24'h115959, 24'h120000, 1'b1);
        tick_case(24'h105958, 24'h105959, 1'b0);
        tick_case(24'h104959, 24'h105000, 1'b0);
        tick_case(24'h190959, 24'h191000, 1'b0);

        // Load coincident with a tick overrides it and restarts the second
        do_load(1'b0, 24'h100000);
        wait_tick(ok, n);
        chk("coinc_tick_seen", 32'(ok), 32'(1));
        load_time = 24'h045959;
        load      = 1'b1;
        @(negedge CP);
        load      = 1'b0;
        chk("coinc_load_time", 32'(cur_time), 32'(24'h045959));
        chk("coinc_no_chime", 32'(hour_chime), 32'(0));
        wait_tick(ok, n);
        chk("coinc_prescaler_cleared", 32'(n), 32'(9));

        // Two channels matching together, auto-stop after 60 ticks
        wr_alarm(2'd0, 16'h0700, 1'b1);
        wr_alarm(2'd2, 16'h0700, 1'b1);
        do_load(1'b0, 24'h065959);
        wait_tick(ok, n);
        chk("a44_tick", 32'(ok), 32'(1));
        @(negedge CP);
        chk("a44_ring_not_yet", 32'(ringing), 32'(0));
        @(negedge CP);
        chk("a44_ring_start", 32'(ringing), 32'(4'b0101));
        for (int k = 1; k <= 60; k++) begin
            wait_tick(ok, n);
            if (!ok) chk($sformatf("a44_tick_%0d", k), 32'(ok), 32'(1));
            if (k == 60) chk("a44_ring_at_60", 32'(ringing), 32'(4'b0101));
        end
        @(negedge CP);
        chk("a44_ring_end", 32'(ringing), 32'(0));

        // ack stops ringing; a load of the alarm time never triggers
        wr_alarm(2'd1, 16'h0800, 1'b1);
        do_load(1'b0, 24'h075959);
        wait_tick(ok, n);
        chk("a45_tick", 32'(ok), 32'(1));
        repeat (2) @(negedge CP);
        chk("a45_ring", 32'(ringing), 32'(4'b0010));
        ack = 1'b1;
        @(negedge CP);
        ack = 1'b0;
        chk("a45_ack", 32'(ringing), 32'(0));
        do_load(1'b0, 24'h080000);
        repeat (2) @(negedge CP);
        chk("a45_load_no_ring", 32'(ringing), 32'(0));
        wait_tick(ok, n);
        repeat (2) @(negedge CP);
        chk("a45_load_no_ring_later", 32'(ringing), 32'(0));

        // Rejected alarm_wr leaves a ringing channel alone; valid write stops it
        wr_alarm(2'd3, 16'h0900, 1'b1);
        do_load(1'b0, 24'h085959);
        wait_tick(ok, n);
        repeat (2) @(negedge CP);
        chk("wr_ring", 32'(ringing), 32'(4'b1000));
        wr_alarm(2'd3, 16'h2400, 1'b1);
        chk("wr_bad_err", 32'(load_err), 32'(1));
        chk("wr_bad_keeps_ring", 32'(ringing), 32'(4'b1000));
        wr_alarm(2'd3, 16'h0900, 1'b0);
        chk("wr_good_no_err", 32'(load_err), 32'(0));
        chk("wr_stops_ring", 32'(ringing), 32'(0));

`ifdef MULTI_ALARM_SNOOZE_EN
        // Snooze for 300 ticks, then ring again
        do_load(1'b0, 24'h065959);
        wait_tick(ok, n);
        repeat (2) @(negedge CP);
        chk("snz_ring", 32'(ringing), 32'(4'b0101));
        snooze = 1'b1;
        @(negedge CP);
        snooze = 1'b0;
        chk("snz_silent", 32'(ringing), 32'(0));
        for (int k = 1; k <= 300; k++) begin
            wait_tick(ok, n);
            if (!ok) chk($sformatf("snz_tick_%0d", k), 32'(ok), 32'(1));
            if (k == 300) chk("snz_silent_at_300", 32'(ringing), 32'(0));
        end
        @(negedge CP);
        chk("snz_ring_again", 32'(ringing), 32'(4'b0101));
        ack = 1'b1;
        @(negedge CP);
        ack = 1'b0;
        chk("snz_ack", 32'(ringing), 32'(0));
`endif

        // Reset beats a coincident load; enables are cleared
        @(negedge CP);
        cr        = 1'b1;
        load_time = 24'h123456;
        load      = 1'b1;
        @(negedge CP);
        cr        = 1'b0;
        load      = 1'b0;
        chk("rst_prio_time", 32'(cur_time), 32'(0));
        chk("rst_prio_err", 32'(load_err), 32'(0));
        do_load(1'b0, 24'h065959);
        wait_tick(ok, n);
        repeat (2) @(negedge CP);
        chk("rst_clears_enables", 32'(ringing), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
